// File: rtl/chacha20_pkg.sv
// Shared constants and state encoding for the ChaCha20 keystream consumer/producer pair.
package chacha20_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 16;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [31:0] CTR_MAX         = 32'hFFFF_FFFF;

  // "expand 32-byte k" as little-endian words, first row of the generator state
  localparam logic [31:0] CHACHA_C0 = 32'h6170_7865;
  localparam logic [31:0] CHACHA_C1 = 32'h3320_646e;
  localparam logic [31:0] CHACHA_C2 = 32'h7962_2d32;
  localparam logic [31:0] CHACHA_C3 = 32'h6b20_6574;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT_KS = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DRAIN   = 3'd4
  } xor_state_e;

endpackage

// File: rtl/chacha20_stream_xor.sv
// XORs a 32-bit AXI-Stream with ChaCha20 keystream blocks, driving the generator's block counter.
// state    | meaning
// IDLE     | no message; waiting for i_msg_start
// REQ      | o_ks_start high for one cycle
// WAIT_KS  | waiting for i_keystream_valid
// STREAM   | XOR input words against buffered block
// DRAIN    | message over; waiting for last output word to leave
module chacha20_stream_xor
  import chacha20_pkg::*;
(
  input  logic         i_aclk,
  input  logic         i_aresetn,
  input  logic         i_enable,
  input  logic         i_msg_start,
  input  logic [31:0]  i_init_counter,
  output logic         o_ks_start,
  output logic [31:0]  o_ks_counter,
  input  logic [511:0] i_keystream,
  input  logic         i_keystream_valid,
  input  logic [31:0]  s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  output logic [31:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         o_busy,
  output logic         o_ctr_overflow
);

  xor_state_e state_q;
  logic [WORDS_PER_BLOCK-1:0][DATA_WIDTH-1:0] ks_buf_q;
  logic [IDX_W-1:0] idx_q;
  logic in_hs;
  logic out_drain;

  assign s_axis_tready = i_enable && (state_q == ST_STREAM) && (!m_axis_tvalid || m_axis_tready);
  assign in_hs         = s_axis_tready && s_axis_tvalid;
  assign out_drain     = m_axis_tvalid && m_axis_tready;
  assign o_busy        = (state_q != ST_IDLE);

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q        <= ST_IDLE;
      ks_buf_q       <= '0;
      idx_q          <= '0;
      o_ks_start     <= 1'b0;
      o_ks_counter   <= '0;
      o_ctr_overflow <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
    end else if (!i_enable) begin
      // abort drops any buffered output; the overflow flag survives
      state_q       <= ST_IDLE;
      o_ks_start    <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      o_ks_start <= 1'b0;

      if (in_hs) begin
        m_axis_tdata  <= s_axis_tdata ^ ks_buf_q[idx_q];
        m_axis_tlast  <= s_axis_tlast;
        m_axis_tvalid <= 1'b1;
      end else if (out_drain) begin
        m_axis_tvalid <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (i_msg_start) begin
            o_ks_counter   <= i_init_counter;
            o_ctr_overflow <= 1'b0;
            o_ks_start     <= 1'b1;
            state_q        <= ST_REQ;
          end
        end
        ST_REQ: state_q <= ST_WAIT_KS;
        ST_WAIT_KS: begin
          if (i_keystream_valid) begin
            ks_buf_q <= i_keystream;
            idx_q    <= '0;
            state_q  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (in_hs) begin
            if (s_axis_tlast) begin
              state_q <= ST_DRAIN;
            end else if (idx_q == IDX_LAST) begin
              // never wrap the counter: reusing a block counter reuses keystream
              if (o_ks_counter == CTR_MAX) begin
                o_ctr_overflow <= 1'b1;
                state_q        <= ST_DRAIN;
              end else begin
                o_ks_counter <= o_ks_counter + 32'd1;
                o_ks_start   <= 1'b1;
                state_q      <= ST_REQ;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!m_axis_tvalid || m_axis_tready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
